// File: rtl/bus_reg_bank.sv
// bus_reg_bank: architectural register bank on the consuming side of the
// 16-bit data bus. AR/IR/PC are 8 bits wide and take the low byte of BUS;
// R/S/T/U/AC are 16 bits wide. PC, R and AC can also increment, R and AC
// can be cleared, AC can load the ALU result, and Z is a registered flag
// that records whether the last value written to AC was zero.
module bus_reg_bank (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] BUS,
    input  logic [7:0]  Load,
    input  logic [2:0]  Inc,
    input  logic [1:0]  Clr,
    input  logic        AluLd,
    input  logic [15:0] AluOut,
    output logic [7:0]  AR,
    output logic [7:0]  IR,
    output logic [7:0]  PC,
    output logic [15:0] R,
    output logic [15:0] S,
    output logic [15:0] T,
    output logic [15:0] U,
    output logic [15:0] AC,
    output logic        Z
);

    logic [7:0]  bus_low;
    logic [7:0]  pc_next;
    logic [15:0] r_next;
    logic [15:0] ac_next;
    logic        ac_write;

    assign bus_low = BUS[7:0];

    // Next-state selection for the registers that have more than one update
    // source; each register resolves its own priority independently.
    always_comb begin
        pc_next  = PC;
        r_next   = R;
        ac_next  = AC;
        ac_write = 1'b0;

        if (Load[2]) begin
            pc_next = bus_low;
        end else if (Inc[0]) begin
            pc_next = PC + 8'd1;
        end

        if (Clr[0]) begin
            r_next = 16'h0000;
        end else if (Load[3]) begin
            r_next = BUS;
        end else if (Inc[1]) begin
            r_next = R + 16'd1;
        end

        if (Clr[1]) begin
            ac_next  = 16'h0000;
            ac_write = 1'b1;
        end else if (AluLd) begin
            ac_next  = AluOut;
            ac_write = 1'b1;
        end else if (Load[7]) begin
            ac_next  = BUS;
            ac_write = 1'b1;
        end else if (Inc[2]) begin
            ac_next  = AC + 16'd1;
            ac_write = 1'b1;
        end
    end

    // State register: synchronous reset clears everything and sets Z;
    // Z follows the value being written into AC, not the old AC.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            AR <= 8'h00;
            IR <= 8'h00;
            PC <= 8'h00;
            R  <= 16'h0000;
            S  <= 16'h0000;
            T  <= 16'h0000;
            U  <= 16'h0000;
            AC <= 16'h0000;
            Z  <= 1'b1;
        end else begin
            if (Load[0]) begin
                AR <= bus_low;
            end
            if (Load[1]) begin
                IR <= bus_low;
            end
            if (Load[4]) begin
                S <= BUS;
            end
            if (Load[5]) begin
                T <= BUS;
            end
            if (Load[6]) begin
                U <= BUS;
            end
            PC <= pc_next;
            R  <= r_next;
            AC <= ac_next;
            if (ac_write) begin
                Z <= (ac_next == 16'h0000);
            end
        end
    end

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank: table-driven directed test of bus_reg_bank, followed by
// a few hand-written multi-cycle sequences.
module tb_bus_reg_bank;

    logic        Clk;
    logic        Rst;
    logic [15:0] BUS;
    logic [7:0]  Load;
    logic [2:0]  Inc;
    logic [1:0]  Clr;
    logic        AluLd;
    logic [15:0] AluOut;
    logic [7:0]  AR;
    logic [7:0]  IR;
    logic [7:0]  PC;
    logic [15:0] R;
    logic [15:0] S;
    logic [15:0] T;
    logic [15:0] U;
    logic [15:0] AC;
    logic        Z;

    int checks;
    int failures;

    typedef struct packed {
        logic        rst;
        logic [15:0] bus;
        logic [7:0]  load;
        logic [2:0]  inc;
        logic [1:0]  clr;
        logic        alu_ld;
        logic [15:0] alu_out;
        logic [7:0]  ar;
        logic [7:0]  ir;
        logic [7:0]  pc;
        logic [15:0] r;
        logic [15:0] s;
        logic [15:0] t;
        logic [15:0] u;
        logic [15:0] ac;
        logic        z;
    } vec_t;

    localparam int NUM_VECS = 21;
    vec_t vecs [NUM_VECS];

    bus_reg_bank dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .BUS    (BUS),
        .Load   (Load),
        .Inc    (Inc),
        .Clr    (Clr),
        .AluLd  (AluLd),
        .AluOut (AluOut),
        .AR     (AR),
        .IR     (IR),
        .PC     (PC),
        .R      (R),
        .S      (S),
        .T      (T),
        .U      (U),
        .AC     (AC),
        .Z      (Z)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [15:0] bus, input logic [7:0] load,
                         input logic [2:0] inc, input logic [1:0] clr,
                         input logic alu_ld, input logic [15:0] alu_out);
        @(negedge Clk);
        Rst    = rst;
        BUS    = bus;
        Load   = load;
        Inc    = inc;
        Clr    = clr;
        AluLd  = alu_ld;
        AluOut = alu_out;
    endtask

    task automatic clock_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        drive(v.rst, v.bus, v.load, v.inc, v.clr, v.alu_ld, v.alu_out);
        clock_edge();
    endtask

    task automatic check_vector(input int idx, input vec_t v);
        check_output($sformatf("v%0d.AR", idx), {8'h00, AR}, {8'h00, v.ar});
        check_output($sformatf("v%0d.IR", idx), {8'h00, IR}, {8'h00, v.ir});
        check_output($sformatf("v%0d.PC", idx), {8'h00, PC}, {8'h00, v.pc});
        check_output($sformatf("v%0d.R", idx), R, v.r);
        check_output($sformatf("v%0d.S", idx), S, v.s);
        check_output($sformatf("v%0d.T", idx), T, v.t);
        check_output($sformatf("v%0d.U", idx), U, v.u);
        check_output($sformatf("v%0d.AC", idx), AC, v.ac);
        check_output($sformatf("v%0d.Z", idx), {15'h0, Z}, {15'h0, v.z});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Rst      = 1'b1;
        BUS      = 16'h0000;
        Load     = 8'h00;
        Inc      = 3'b000;
        Clr      = 2'b00;
        AluLd    = 1'b0;
        AluOut   = 16'h0000;

        //            rst   bus       load   inc     clr    ald   aluout     AR     IR     PC     R          S          T          U          AC         Z
        vecs[0]  = '{1'b1, 16'h0000, 8'h00, 3'b000, 2'b00, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[1]  = '{1'b0, 16'h1111, 8'hFF, 3'b000, 2'b00, 1'b0, 16'h0000, 8'h11, 8'h11, 8'h11, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 1'b0};
        vecs[2]  = '{1'b1, 16'h2222, 8'hFF, 3'b111, 2'b00, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 16'hA5C3, 8'hFF, 3'b000, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'hC3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b0};
        vecs[4]  = '{1'b0, 16'hFFFF, 8'h8C, 3'b000, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'hFF, 16'hFFFF, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hFFFF, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 8'h00, 3'b111, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h00, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 16'h5678, 8'h80, 3'b100, 2'b10, 1'b1, 16'h1234, 8'hC3, 8'hC3, 8'h00, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 16'h5678, 8'h80, 3'b100, 2'b00, 1'b1, 16'h1234, 8'hC3, 8'hC3, 8'h00, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h1234, 1'b0};
        vecs[8]  = '{1'b0, 16'h5678, 8'h80, 3'b100, 2'b00, 1'b0, 16'h1234, 8'hC3, 8'hC3, 8'h00, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h5678, 1'b0};
        vecs[9]  = '{1'b0, 16'h0010, 8'h04, 3'b000, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h10, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h5678, 1'b0};
        vecs[10] = '{1'b0, 16'h0040, 8'h04, 3'b001, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h40, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h5678, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 8'h00, 3'b001, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h41, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h5678, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 8'h00, 3'b001, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h42, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h5678, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 8'h00, 3'b001, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h43, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h5678, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 8'h00, 3'b000, 2'b10, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h43, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0000, 1'b1};
        vecs[15] = '{1'b0, 16'h0001, 8'h08, 3'b000, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h43, 16'h0001, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0000, 1'b1};
        vecs[16] = '{1'b0, 16'h0000, 8'h00, 3'b100, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h43, 16'h0001, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0001, 1'b0};
        vecs[17] = '{1'b0, 16'h7777, 8'h08, 3'b010, 2'b01, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h43, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0001, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 8'h00, 3'b010, 2'b00, 1'b0, 16'h0000, 8'hC3, 8'hC3, 8'h43, 16'h0001, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'h0001, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 8'hFF, 3'b000, 2'b00, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[20] = '{1'b0, 16'h0000, 8'h00, 3'b111, 2'b00, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h01, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0};

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i]);
            check_vector(i, vecs[i]);
        end

        // AC held increment across the 16-bit wrap, with Z following each write.
        drive(1'b0, 16'hFFFE, 8'h80, 3'b000, 2'b00, 1'b0, 16'h0000);
        clock_edge();
        check_output("wrap.load_AC", AC, 16'hFFFE);
        check_output("wrap.load_Z", {15'h0, Z}, 16'h0000);
        drive(1'b0, 16'h0000, 8'h00, 3'b100, 2'b00, 1'b0, 16'h0000);
        clock_edge();
        check_output("wrap.inc1_AC", AC, 16'hFFFF);
        check_output("wrap.inc1_Z", {15'h0, Z}, 16'h0000);
        clock_edge();
        check_output("wrap.inc2_AC", AC, 16'h0000);
        check_output("wrap.inc2_Z", {15'h0, Z}, 16'h0001);

        // Outputs must not move before the clock edge that samples the new controls.
        drive(1'b0, 16'hABCD, 8'hFF, 3'b000, 2'b00, 1'b0, 16'h0000);
        #2;
        check_output("noflow.AR_before", {8'h00, AR}, 16'h0000);
        check_output("noflow.AC_before", AC, 16'h0000);
        clock_edge();
        check_output("noflow.AR_after", {8'h00, AR}, 16'h00CD);
        check_output("noflow.AC_after", AC, 16'hABCD);

        // Reset discards a simultaneous ALU load; the first edge after release acts.
        drive(1'b1, 16'h0000, 8'h00, 3'b000, 2'b00, 1'b1, 16'h0042);
        clock_edge();
        check_output("rst_alu.AC", AC, 16'h0000);
        check_output("rst_alu.Z", {15'h0, Z}, 16'h0001);
        drive(1'b0, 16'h0000, 8'h00, 3'b000, 2'b00, 1'b1, 16'h0042);
        clock_edge();
        check_output("release.AC", AC, 16'h0042);
        check_output("release.Z", {15'h0, Z}, 16'h0000);

        drive(1'b0, 16'h0000, 8'h00, 3'b000, 2'b00, 1'b0, 16'h0000);
        clock_edge();
        check_output("idle.AC", AC, 16'h0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_reg_bank.md
# bus_reg_bank

Register bank on the consuming side of the processor's 16-bit data bus. It holds the architectural registers AR, IR, PC, R, S, T, U and AC, whose outputs drive the bus multiplexer. Each register loads the current BUS value under control-unit load enables, and PC, R and AC also support increment. AC additionally loads the ALU result and can be cleared, and a registered zero flag tracks AC.

## Interface
- No parameters. Register set and widths are fixed by the datapath.
- Clk, input, 1: sole clock. All state updates on the rising edge.
- Rst, input, 1: synchronous, active-high reset, sampled on the rising edge of Clk.
- BUS, input, 16: current bus value from the bus multiplexer.
- Load, input, 8: per-register load enables. Bit 0 AR, 1 IR, 2 PC, 3 R, 4 S, 5 T, 6 U, 7 AC. Any combination of bits may be set.
- Inc, input, 3: increment enables. Bit 0 PC, 1 R, 2 AC.
- Clr, input, 2: clear enables. Bit 0 R, 1 AC.
- AluLd, input, 1: load AC from AluOut.
- AluOut, input, 16: ALU result.
- AR, output, 8: address register (data-memory address).
- IR, output, 8: instruction register.
- PC, output, 8: program counter (instruction-memory address).
- R, S, T, U, output, 16 each: general registers.
- AC, output, 16: accumulator.
- Z, output, 1: zero flag, registered. Equals 1 when the last value written to AC was zero.

## Operation
- Reset: all registers clear to 0 and Z is set to 1. Rst overrides every other control input in the same cycle.
- Each register has its own update priority, evaluated independently per register every cycle:
  - AR, IR, S, T, U: Load, else hold.
  - PC: Load, else Inc, else hold.
  - R: Clr, else Load, else Inc, else hold.
  - AC: Clr, else AluLd, else Load, else Inc, else hold.
- Width rules:
  - The 8-bit registers (AR, IR, PC) take BUS[7:0]. BUS[15:8] is ignored.
  - The 16-bit registers take all of BUS.
- Increment is modulo the register width:
  - PC 8'hFF -> 8'h00.
  - R and AC 16'hFFFF -> 16'h0000.
  - No carry or overflow output.
- Z update rule:
  - Z is updated only in cycles where AC is written (Clr, AluLd, Load or Inc on AC). Z becomes 1 exactly when the value written to AC is zero.
  - On a hold cycle, Z keeps its value.
  - Z is derived from the next-state AC value, not the current one.
- Several Load bits set together all capture the same BUS value in the same edge. This is the broadcast copy, e.g. BUS to R and S together.
- A register that is the bus source and also loads from BUS keeps its value (self-copy). There is no special case.
- Load and Inc on the same register: Load wins and no increment occurs.
- Conflicting control combinations are legal and are resolved by the priorities above. No error output.

## Timing
- Single cycle. A register written at rising edge N shows its new value from edge N onward, so it is visible to the bus mux and control unit in cycle N+1.
- Outputs come directly from flops. There is no combinational path from any input to any output.
- BUS is sampled at the edge, so the upstream mux path (register -> mux -> BUS -> register) is one full cycle.
- Reset mid-operation: a Rst asserted in the same cycle as any Load, Inc, Clr or AluLd discards that operation. All registers read 0 and Z reads 1 after the edge.
- Reset release: the first active operation takes effect on the first edge with Rst low.
- No handshake. Control inputs are level-sensitive per cycle, and holding Inc high increments once per cycle.

## Test plan
- Reset: preload every register with nonzero values, then assert Rst together with Load=8'hFF and Inc=3'b111. Required after the edge: AR, IR, PC, R, S, T, U and AC all 0, and Z=1.
- Width truncation and broadcast: BUS=16'hA5C3, Load=8'hFF for one cycle. Required: AR=IR=PC=8'hC3, R=S=T=U=AC=16'hA5C3, and Z=0.
- Wrap-around: load PC=8'hFF, R=16'hFFFF and AC=16'hFFFF, then Inc=3'b111 for one cycle. Required: PC=8'h00, R=16'h0000, AC=16'h0000 and Z=1.
- Priority on AC:
  - With Clr[1]=1, AluLd=1, AluOut=16'h1234, Load[7]=1, BUS=16'h5678 and Inc[2]=1, AC must become 0 and Z=1.
  - Next cycle, drop Clr only: AC must become 16'h1234 and Z=0.
  - Next cycle, drop AluLd: AC must become 16'h5678.
- Load-over-increment: PC=8'h10, Load[2]=1 with BUS=16'h0040 and Inc[0]=1 gives PC=8'h40. Then Inc[0]=1 held for 3 cycles gives PC=8'h43.
- Z hold: write AC=0 (Z=1), then load R=16'h0001 while AC is idle. Z must stay 1. Then Inc[2]=1 gives AC=16'h0001 and Z=0.
